lector_registro: RTL and testbench
==================================

// Module: lector_registro
// PURPOSE
//  Read side of the push-register interface: captures words strobed in with push_i/data_i,
//  buffers them in a DEPTH-entry circular queue and hands them to a consumer via pop_i.
//  Sits between a push-style producer and any downstream block that drains one word
//  per request; flags overflow/underflow so protocol misuse is visible in simulation and on board.
// PARAMETERS
//  N      32  data width in bits
//  DEPTH  4   queue entries, >=2, need not be a power of two
// PORTS
//  clk_i       in   1              system clock, all state updates on rising edge
//  rst_i       in   1              synchronous reset, active-low
//  push_i      in   1              write strobe, level-sampled: one word per cycle while high
//  data_i      in   N              word written when push_i accepted
//  pop_i       in   1              read request: consume head word this cycle
//  data_o      out  N              head word (oldest); 0 when empty
//  valid_o     out  1              data_o holds a valid word (= !empty_o)
//  empty_o     out  1              count_o == 0
//  full_o      out  1              count_o == DEPTH
//  count_o     out  $clog2(DEPTH+1) words stored
//  overflow_o  out  1              sticky: push attempted while full and not popping
//  underflow_o out  1              sticky: pop attempted while empty
// BEHAVIOUR
//  - Single clock clk_i; reset synchronous, active-low (rst_i==0 sampled at rising edge).
//  - Reset: wr_ptr=rd_ptr=0, count_o=0, state VACIO, empty_o=1, full_o=0, valid_o=0,
//    data_o=0, overflow_o=0, underflow_o=0. Storage contents not cleared (don't care).
//  - Reset wins over push_i/pop_i in the same cycle; mid-operation reset discards all words.
//  - FSM (state from registered count): VACIO(count=0) / PARCIAL(0<count<DEPTH) / LLENO(count=DEPTH).
//    VACIO->PARCIAL on accepted push; PARCIAL->LLENO on push w/o pop at count=DEPTH-1;
//    PARCIAL->VACIO on pop w/o push at count=1; LLENO->PARCIAL on pop w/o push.
//  - Push accepted iff push_i && (!full || pop_i). Accepted: mem[wr_ptr]<=data_i, wr_ptr advances.
//  - Pop accepted iff pop_i && !empty. Accepted: rd_ptr advances.
//  - count_o: +1 push only, -1 pop only, unchanged on both or neither.
//  - Pointers wrap DEPTH-1 -> 0 by explicit compare (no modulo on non-power-of-2).
//  - data_o = mem[rd_ptr] when !empty, else 0 (first-word fall-through, read is combinational).
//  - Latency: word pushed at edge k appears on data_o after edge k if queue was empty.
//  - Full + push + pop: both accepted, count stays DEPTH, no overflow.
//  - Empty + push + pop: push accepted, pop rejected (no bypass), underflow_o set, count->1.
//  - Full + push, no pop: word dropped, contents unchanged, overflow_o<=1.
//  - overflow_o/underflow_o stay 1 until reset.
// STRUCTURE
//  - Package lector_pkg: typedef enum logic[1:0] {VACIO,PARCIAL,LLENO} estado_t;
//    function next_ptr(ptr, depth) for wrap arithmetic.
//  - Storage: unpacked array logic [N-1:0] mem[DEPTH], written in always_ff, no reset.
//  - One natural sub-module: ctrl_punteros (pointers, count, FSM, flags); datapath in top.
// TESTING (N=8, DEPTH=4)
//  1 reset: rst_i=0 two cycles with push_i=1 -> count_o=0, empty_o=1, data_o=0, flags 0.
//  2 push 0x11,0x22,0x33,0x44 back-to-back -> full_o=1, count_o=4, data_o=0x11;
//    5th push 0x55 -> overflow_o=1, data_o stays 0x11, count_o=4.
//  3 from full, push 0x66 + pop same cycle -> count_o=4, data_o=0x22, overflow_o unchanged;
//    drain 4 pops -> 0x22,0x33,0x44,0x66 then empty_o=1, data_o=0.
//  4 wrap: 6 alternating push/pop pairs of 0xA0..0xA5 -> each word on data_o in order,
//    pointers wrap past 3, count never >1.
//  5 empty, push 0x77 + pop same cycle -> underflow_o=1, count_o=1, data_o=0x77.
//  6 reset mid-stream with count_o=3 -> next cycle count_o=0, empty_o=1, flags cleared.

Source files
------------

// File: rtl/lector_registro_pkg.sv
// Shared types and helpers for the push-register read-side queue.
package lector_pkg;

  typedef enum logic [1:0] {
    VACIO   = 2'd0,
    PARCIAL = 2'd1,
    LLENO   = 2'd2
  } estado_t;

  // Circular increment that wraps by compare, so DEPTH need not be a power of two.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? '0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/lector_registro_ctrl_punteros.sv
// Pointer, occupancy and protocol-flag control for the lector_registro queue.
module ctrl_punteros
  import lector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  output logic          push_ok_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  estado_t       r_estado, w_estado_sig;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_sig;
  logic          r_ovf, r_udf;
  logic          w_empty, w_full, w_push_ok, w_pop_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push_ok = push_i && (!w_full || pop_i);
  assign w_pop_ok  = pop_i && !w_empty;

  always_comb begin
    w_count_sig  = r_count;
    w_estado_sig = r_estado;
    if (w_push_ok && !w_pop_ok)      w_count_sig = r_count + CW'(1);
    else if (w_pop_ok && !w_push_ok) w_count_sig = r_count - CW'(1);

    case (r_estado)
      VACIO:   if (w_push_ok) w_estado_sig = PARCIAL;
      PARCIAL: begin
        if (w_push_ok && !w_pop_ok && r_count == CW'(DEPTH - 1))
          w_estado_sig = LLENO;
        else if (w_pop_ok && !w_push_ok && r_count == CW'(1))
          w_estado_sig = VACIO;
      end
      LLENO:   if (w_pop_ok && !w_push_ok) w_estado_sig = PARCIAL;
      default: w_estado_sig = VACIO;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_estado <= VACIO;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      r_count  <= w_count_sig;
      if (w_push_ok) r_wr_ptr <= PW'(next_ptr(32'(r_wr_ptr), 32'(DEPTH)));
      if (w_pop_ok)  r_rd_ptr <= PW'(next_ptr(32'(r_rd_ptr), 32'(DEPTH)));
      if (push_i && w_full && !pop_i) r_ovf <= 1'b1;
      if (pop_i && w_empty)           r_udf <= 1'b1;
    end
  end

  assign push_ok_o   = w_push_ok;
  assign wr_ptr_o    = r_wr_ptr;
  assign rd_ptr_o    = r_rd_ptr;
  assign count_o     = r_count;
  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_udf;

endmodule

// File: rtl/lector_registro.sv
// Read side of the push-register interface: DEPTH-entry circular queue with fall-through head.
module lector_registro
  import lector_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [N-1:0]               data_i,
  input  logic                       pop_i,
  output logic [N-1:0]               data_o,
  output logic                       valid_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  r_mem [DEPTH];
  logic          w_push_ok, w_empty;
  logic [PW-1:0] w_wr_ptr, w_rd_ptr;

  ctrl_punteros #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .push_ok_o   (w_push_ok),
    .wr_ptr_o    (w_wr_ptr),
    .rd_ptr_o    (w_rd_ptr),
    .count_o     (count_o),
    .empty_o     (w_empty),
    .full_o      (full_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  // Storage is deliberately left out of reset; stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[w_wr_ptr] <= data_i;
  end

  assign data_o  = w_empty ? '0 : r_mem[w_rd_ptr];
  assign empty_o = w_empty;
  assign valid_o = !w_empty;

endmodule

// File: tb/tb_lector_registro.sv
// Scoreboard bench for lector_registro (N=8, DEPTH=4) against a queue-based reference model.
module tb_lector_registro;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         push_i = 1'b0;
  logic         pop_i = 1'b0;
  logic [N-1:0] data_i = '0;
  logic [N-1:0] data_o;
  logic         valid_o, empty_o, full_o, overflow_o, underflow_o;
  logic [2:0]   count_o;

  lector_registro #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .data_i      (data_i),
    .pop_i       (pop_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0] d;
    int unsigned  cnt;
    bit           ovf;
    bit           udf;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] mq[$];
  bit           m_ovf = 0, m_udf = 0;
  int unsigned  n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the queue itself, advanced by the rules of one clock edge.
  task automatic model(input bit r, input bit p, input bit q, input logic [N-1:0] d);
    bit was_full, was_empty;
    if (!r) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
      return;
    end
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (q && was_empty) m_udf = 1;
    if (p && was_full && !q) m_ovf = 1;
    if (q && !was_empty) void'(mq.pop_front());
    if (p && (!was_full || q)) mq.push_back(d);
  endtask

  task automatic step(input bit r, input bit p, input bit q, input logic [N-1:0] d);
    exp_t e;
    @(negedge clk_i);
    rst_i  = r;
    push_i = p;
    pop_i  = q;
    data_i = d;
    model(r, p, q, d);
    e.cnt = mq.size();
    e.d   = (mq.size() != 0) ? mq[0] : '0;
    e.ovf = m_ovf;
    e.udf = m_udf;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_o",      32'(data_o),      32'(e.d));
        check("count_o",     32'(count_o),     e.cnt);
        check("empty_o",     32'(empty_o),     32'(e.cnt == 0));
        check("valid_o",     32'(valid_o),     32'(e.cnt != 0));
        check("full_o",      32'(full_o),      32'(e.cnt == DEPTH));
        check("overflow_o",  32'(overflow_o),  32'(e.ovf));
        check("underflow_o", 32'(underflow_o), 32'(e.udf));
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] seq4 [4];
    seq4 = '{8'h11, 8'h22, 8'h33, 8'h44};

    step(0, 1, 0, 8'hEE);
    step(0, 1, 0, 8'hEF);

    foreach (seq4[i]) step(1, 1, 0, seq4[i]);
    step(1, 1, 0, 8'h55);                       // dropped while full

    step(1, 1, 1, 8'h66);                       // full push+pop
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'h00);

    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 8'hA0 + 8'(i));
      step(1, 0, 1, 8'h00);
    end

    step(1, 1, 1, 8'h77);                       // empty push+pop: no bypass
    step(1, 0, 0, 8'h00);

    step(1, 1, 0, 8'h78);
    step(1, 1, 0, 8'h79);
    step(0, 1, 1, 8'h7A);                       // reset with three words held
    step(1, 0, 0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0 ? 1'b1 : ($urandom_range(0, 1) == 1),
           8'($urandom));
    end
    step(1, 0, 0, 8'h00);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk_i);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
